// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel: word alignment by control-token hunting
// with bitslip requests, then decode of video data, control data and VDE.
module tmds_decoder #(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 64,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic [9:0] TMDS,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       aligned,
  output logic       bitslip,
  output logic [7:0] slip_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT) + 1;
  localparam int WIN_W = $clog2(SEARCH_WINDOW) + 1;
  localparam int SET_W = $clog2(SLIP_SETTLE) + 1;
  localparam int GAP_W = $clog2(LOSS_TIMEOUT) + 1;

  // Last count value before each limit fires; comparing against limit-1 lets
  // the transition happen on the same edge that would reach the limit.
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, SLIP_WAIT, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic [SET_W-1:0] set_cnt, set_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [7:0]       slip_nxt;
  logic [7:0]       vd_nxt;
  logic [1:0]       cd_nxt;
  logic             vde_nxt;
  logic             is_tok;
  logic [1:0]       tok_cd;
  logic [7:0]       data_dec;

  // Undo the transition-minimising encoding: optional inversion, then XOR/XNOR chain.
  function automatic logic [7:0] decode_data(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Saturating increment so the slip counter parks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Control token recognition and the data decode of the current word.
  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    unique case (TMDS)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_tok = 1'b0;
    endcase
    data_dec = decode_data(TMDS);
  end

  // Next-state, counter and output computation for the alignment FSM.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    win_nxt   = win_cnt;
    set_nxt   = set_cnt;
    gap_nxt   = gap_cnt;
    slip_nxt  = slip_count;
    unique case (state)
      SEARCH: begin
        if (is_tok && run_cnt == RUN_LAST) begin
          state_nxt = LOCKED;
          run_nxt   = '0;
          win_nxt   = '0;
          gap_nxt   = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_nxt = SLIP;
          run_nxt   = '0;
          win_nxt   = '0;
          slip_nxt  = sat_inc(slip_count);
        end else begin
          win_nxt = win_cnt + WIN_W'(1);
          run_nxt = is_tok ? run_cnt + RUN_W'(1) : '0;
        end
      end
      SLIP: begin
        state_nxt = SLIP_WAIT;
        set_nxt   = '0;
      end
      SLIP_WAIT: begin
        if (set_cnt == SET_LAST) begin
          state_nxt = SEARCH;
          set_nxt   = '0;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          set_nxt = set_cnt + SET_W'(1);
        end
      end
      LOCKED: begin
        if (is_tok) begin
          gap_nxt = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt = SEARCH;
          gap_nxt   = '0;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = SEARCH;
    endcase

    // Outputs follow the state this edge moves into.
    vd_nxt  = 8'd0;
    cd_nxt  = 2'b00;
    vde_nxt = 1'b0;
    if (state_nxt == LOCKED) begin
      if (is_tok) begin
        cd_nxt = tok_cd;
      end else begin
        vde_nxt = 1'b1;
        vd_nxt  = data_dec;
        cd_nxt  = CD;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      win_cnt    <= '0;
      set_cnt    <= '0;
      gap_cnt    <= '0;
      slip_count <= 8'd0;
      VD         <= 8'd0;
      CD         <= 2'b00;
      VDE        <= 1'b0;
      aligned    <= 1'b0;
      bitslip    <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      win_cnt    <= win_nxt;
      set_cnt    <= set_nxt;
      gap_cnt    <= gap_nxt;
      slip_count <= slip_nxt;
      VD         <= vd_nxt;
      CD         <= cd_nxt;
      VDE        <= vde_nxt;
      aligned    <= (state_nxt == LOCKED);
      bitslip    <= (state_nxt == SLIP);
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder.
module tb_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'b0100000000;  // decodes to 0x00
  localparam logic [9:0] DFF = 10'b1000000000;  // decodes to 0xFF
  localparam logic [9:0] D03 = 10'b0100000001;  // decodes to 0x03
  localparam logic [9:0] D10 = 10'b1100001111;  // decodes to 0x10

  logic       pixclk;
  logic       rst;
  logic [9:0] TMDS;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       aligned;
  logic       bitslip;
  logic [7:0] slip_count;

  int checks = 0;
  int errors = 0;

  tmds_decoder dut (
    .pixclk    (pixclk),
    .rst       (rst),
    .TMDS      (TMDS),
    .VD        (VD),
    .CD        (CD),
    .VDE       (VDE),
    .aligned   (aligned),
    .bitslip   (bitslip),
    .slip_count(slip_count)
  );

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one word, let one edge sample it, then settle past the edge.
  task automatic step(input logic [9:0] w);
    TMDS = w;
    @(posedge pixclk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] vd, input logic [1:0] cd,
                         input logic vde, input logic al, input logic bs, input logic [7:0] sc);
    chk({tag, ".VD"}, 32'(VD), 32'(vd));
    chk({tag, ".CD"}, 32'(CD), 32'(cd));
    chk({tag, ".VDE"}, 32'(VDE), 32'(vde));
    chk({tag, ".aligned"}, 32'(aligned), 32'(al));
    chk({tag, ".bitslip"}, 32'(bitslip), 32'(bs));
    chk({tag, ".slip_count"}, 32'(slip_count), 32'(sc));
  endtask

  task automatic do_reset(input string tag, input logic [9:0] w);
    rst  = 1'b1;
    TMDS = w;
    @(posedge pixclk);
    #1;
    rst = 1'b0;
    chk_out(tag, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    rst  = 1'b1;
    TMDS = 10'd0;
    @(posedge pixclk);
    #1;
    do_reset("rst0", T00);

    // Lock on eight consecutive CD=00 tokens.
    for (int n = 1; n <= 8; n++) begin
      step(T00);
      chk("lock8.aligned", 32'(aligned), 32'(n == 8));
      chk("lock8.bitslip", 32'(bitslip), 32'd0);
    end
    chk_out("lock8", 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);

    // Data and control decode while locked.
    step(D00); chk_out("d00", 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 8'd0);
    step(DFF); chk_out("dff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 8'd0);
    step(T01); chk_out("t01", 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 8'd0);
    step(T10); chk_out("t10", 8'h00, 2'b10, 1'b0, 1'b1, 1'b0, 8'd0);
    step(T11); chk_out("t11", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 8'd0);
    step(D03); chk_out("d03", 8'h03, 2'b11, 1'b1, 1'b1, 1'b0, 8'd0);
    step(D10); chk_out("d10", 8'h10, 2'b11, 1'b1, 1'b1, 1'b0, 8'd0);

    // Loss of lock: a token at word 4095 restarts the gap, 4096 words drop lock.
    step(T00);
    for (int n = 1; n <= 4094; n++) step(D00);
    chk("gap4094.aligned", 32'(aligned), 32'd1);
    step(T10);
    chk_out("gaptok", 8'h00, 2'b10, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int n = 1; n <= 4095; n++) step(DFF);
    chk_out("gap4095", 8'hFF, 2'b10, 1'b1, 1'b1, 1'b0, 8'd0);
    step(DFF);
    chk_out("gap4096", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);

    // Slip hunting: tokens arriving during SLIP/SLIP_WAIT must not count toward lock.
    do_reset("rst1", D00);
    for (int n = 1; n <= 133; n++) begin
      step((n >= 65 && n <= 76) ? T00 : D00);
      chk("hunt.bitslip", 32'(bitslip), 32'(n == 64 || n == 133));
      chk("hunt.aligned", 32'(aligned), 32'd0);
      chk("hunt.slip_count", 32'(slip_count), (n >= 133) ? 32'd2 : (n >= 64) ? 32'd1 : 32'd0);
    end

    // A data word in the middle of a run restarts the token count.
    do_reset("rst2", D00);
    for (int n = 1; n <= 16; n++) begin
      step((n == 8) ? D00 : T00);
      chk("rerun.aligned", 32'(aligned), 32'(n == 16));
    end

    // A run completing at the last window cycle locks rather than slips.
    do_reset("rst3", D00);
    for (int n = 1; n <= 64; n++) begin
      step((n > 56) ? T11 : D00);
      chk("edge.aligned", 32'(aligned), 32'(n == 64));
      chk("edge.bitslip", 32'(bitslip), 32'd0);
    end
    chk_out("edgelock", 8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 8'd0);
    step(D00);
    chk_out("edgedata", 8'h00, 2'b11, 1'b1, 1'b1, 1'b0, 8'd0);

    // Reset while in SLIP_WAIT clears slip_count too.
    do_reset("rst4", D00);
    for (int n = 1; n <= 66; n++) step(D00);
    chk("wait.slip_count", 32'(slip_count), 32'd1);
    do_reset("rstwait", T00);
    // Search restarts from zero: next slip lands after a full window.
    for (int n = 1; n <= 64; n++) begin
      step(D00);
      chk("resrch.bitslip", 32'(bitslip), 32'(n == 64));
    end
    chk("resrch.slip_count", 32'(slip_count), 32'd1);

    // Reset while locked.
    do_reset("rst5", D00);
    for (int n = 1; n <= 8; n++) step(T11);
    step(DFF);
    chk_out("prelock", 8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, 8'd0);
    do_reset("rstlock", DFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
